// File: rtl/pkt_hdr_buffer_pkg.sv
// Shared types and defaults for the packet header ingress buffer.
// Provides the FSM state type and the default widths used by the top.
package pkt_hdr_buffer_pkg;

  localparam int unsigned HdrMaxLenDefault = 64;
  localparam int unsigned ByteW            = 8;
  localparam int unsigned DataW            = 32;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StDrain,
    StStart,
    StWait
  } pkt_buf_state_t;

  // State after the first byte of a packet is accepted in idle.
  function automatic pkt_buf_state_t first_byte_next(input logic        last,
                                                     input int unsigned hdr_len);
    if (last) begin
      return StStart;
    end
    return (hdr_len == 1) ? StDrain : StFill;
  endfunction

endpackage

// File: rtl/pkt_hdr_buffer.sv
// Captures the first HDR_MAX_LEN bytes of a byte-serial packet, hands them to the parser
// with a one-cycle start pulse and holds them until the parser finishes.
module pkt_hdr_buffer
  import pkt_hdr_buffer_pkg::*;
#(
  parameter int unsigned HDR_MAX_LEN = HdrMaxLenDefault,
  parameter int unsigned LEN_W       = DataW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [ByteW-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic             start_o,
  output logic [ByteW-1:0] pkt_hdr_o [0:HDR_MAX_LEN-1],
  output logic [LEN_W-1:0] pkt_len_o,
  input  logic             parser_ready_i,
  input  logic             cfg_busy_i,
  output logic [LEN_W-1:0] pkt_cnt_o
);

  localparam int unsigned      IdxW    = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LastIdx = LEN_W'(HDR_MAX_LEN - 1);
  localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);

  pkt_buf_state_t   state_q;
  logic [ByteW-1:0] hdr_q [0:HDR_MAX_LEN-1];
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             seen_low_q;

  logic             accept;
  logic             start_fire;
  logic [LEN_W-1:0] len_inc;
  logic [IdxW-1:0]  wr_idx;

  assign in_ready_o = (state_q == StIdle) || (state_q == StFill) || (state_q == StDrain);
  assign accept     = in_valid_i && in_ready_o;

  // A busy parser ignores start, so the pulse is held back until it is free.
  assign start_fire = (state_q == StStart) && !cfg_busy_i;
  assign start_o    = start_fire;

  assign len_inc = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LenOne;
  assign wr_idx  = IdxW'(len_q);

  assign pkt_hdr_o = hdr_q;
  assign pkt_len_o = len_q;
  assign pkt_cnt_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      for (int i = 0; i < HDR_MAX_LEN; i++) begin
        hdr_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            hdr_q[0] <= in_data_i;
            for (int i = 1; i < HDR_MAX_LEN; i++) begin
              hdr_q[i] <= '0;
            end
            len_q   <= LenOne;
            state_q <= first_byte_next(in_last_i, HDR_MAX_LEN);
          end
        end
        StFill: begin
          if (accept) begin
            hdr_q[wr_idx] <= in_data_i;
            len_q         <= len_inc;
            if (in_last_i) begin
              state_q <= StStart;
            end else if (len_q == LastIdx) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (accept) begin
            len_q <= len_inc;
            if (in_last_i) begin
              state_q <= StStart;
            end
          end
        end
        StStart: begin
          if (start_fire) begin
            cnt_q      <= cnt_q + LenOne;
            seen_low_q <= 1'b0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          // Ready may still be high from the previous packet right after start.
          if (!parser_ready_i) begin
            seen_low_q <= 1'b1;
          end
          if (seen_low_q && parser_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pkt_hdr_buffer.sv
// Directed bench for pkt_hdr_buffer with HDR_MAX_LEN = 64 and hand-built expectations.
module tb_pkt_hdr_buffer;

  localparam int unsigned HdrLen = 64;
  localparam int unsigned LenW   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [7:0]      in_data;
  logic            in_last;
  logic            in_ready;
  logic            start;
  logic [7:0]      pkt_hdr [0:HdrLen-1];
  logic [LenW-1:0] pkt_len;
  logic            parser_ready;
  logic            cfg_busy;
  logic [LenW-1:0] pkt_cnt;

  int num_checks = 0;
  int num_errors = 0;

  logic [511:0] exp_hdr;
  logic [511:0] held_hdr;
  int           bad_cnt;
  int           hdr_changed;

  pkt_hdr_buffer #(
    .HDR_MAX_LEN(HdrLen),
    .LEN_W      (LenW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .in_last_i     (in_last),
    .in_ready_o    (in_ready),
    .start_o       (start),
    .pkt_hdr_o     (pkt_hdr),
    .pkt_len_o     (pkt_len),
    .parser_ready_i(parser_ready),
    .cfg_busy_i    (cfg_busy),
    .pkt_cnt_o     (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] hdr_bits();
    logic [511:0] r;
    for (int i = 0; i < HdrLen; i++) r[i*8 +: 8] = pkt_hdr[i];
    return r;
  endfunction

  // Move to 1 time unit after the next rising edge; inputs are driven and outputs sampled here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one byte until accepted; returns in the cycle after acceptance.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    while (!in_ready && n < 50) begin
      next_cycle();
      n++;
    end
    if (n >= 50) check_eq("send_timeout", 512'(0), 512'(1));
    next_cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
  endtask

  // Called in the first wait cycle; drops then raises parser ready so the block returns to idle.
  task automatic finish_parser(input string tag, input int exp_cnt);
    check_eq({tag, "_start_one_cycle"}, 512'(start), 512'(0));
    check_eq({tag, "_cnt"}, 512'(pkt_cnt), 512'(exp_cnt));
    parser_ready = 1'b0;
    next_cycle();
    parser_ready = 1'b1;
    next_cycle();
    check_eq({tag, "_back_idle"}, 512'(in_ready), 512'(1));
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_last      = 1'b0;
    parser_ready = 1'b1;
    cfg_busy     = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b0;
    #1;

    // Reset state
    check_eq("rst_ready", 512'(in_ready), 512'(1));
    check_eq("rst_start", 512'(start), 512'(0));
    check_eq("rst_len", 512'(pkt_len), 512'(0));
    check_eq("rst_cnt", 512'(pkt_cnt), 512'(0));
    check_eq("rst_hdr", hdr_bits(), 512'(0));

    // 20-byte packet, no gaps
    exp_hdr = '0;
    for (int i = 0; i < 20; i++) begin
      exp_hdr[i*8 +: 8] = 8'(i + 1);
      send_byte(8'(i + 1), i == 19);
    end
    check_eq("p20_start", 512'(start), 512'(1));
    check_eq("p20_hdr", hdr_bits(), exp_hdr);
    check_eq("p20_len", 512'(pkt_len), 512'(20));
    check_eq("p20_ready_low", 512'(in_ready), 512'(0));
    next_cycle();
    finish_parser("p20", 1);

    // 100-byte packet with valid gaps; only the first 64 bytes are kept
    exp_hdr = '0;
    bad_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 7 == 3) begin
        for (int g = 0; g < 2; g++) begin
          if (i >= 64 && !in_ready) bad_cnt++;
          next_cycle();
        end
      end
      if (i >= 64 && !in_ready) bad_cnt++;
      if (i < 64) exp_hdr[i*8 +: 8] = 8'(i * 3 + 7);
      send_byte(8'(i * 3 + 7), i == 99);
    end
    check_eq("p100_drain_ready", 512'(bad_cnt), 512'(0));
    check_eq("p100_start", 512'(start), 512'(1));
    check_eq("p100_hdr", hdr_bits(), exp_hdr);
    check_eq("p100_len", 512'(pkt_len), 512'(100));
    held_hdr = exp_hdr;

    // Second packet offered during wait: ready 1 for one cycle, 0 for five, then 1
    next_cycle();
    check_eq("w_start_one_cycle", 512'(start), 512'(0));
    check_eq("w_cnt", 512'(pkt_cnt), 512'(2));
    in_valid = 1'b1;
    in_data  = 8'hC1;
    in_last  = 1'b0;
    #1;
    check_eq("w_ready_first", 512'(in_ready), 512'(0));
    bad_cnt     = 0;
    hdr_changed = 0;
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      parser_ready = 1'b0;
      if (in_ready) bad_cnt++;
      if (hdr_bits() !== held_hdr) hdr_changed++;
    end
    check_eq("w_ready_low", 512'(bad_cnt), 512'(0));
    check_eq("w_hdr_stable", 512'(hdr_changed), 512'(0));
    next_cycle();
    parser_ready = 1'b1;
    #1;
    check_eq("w_ready_at_rise", 512'(in_ready), 512'(0));
    check_eq("w_hdr_at_rise", hdr_bits(), held_hdr);
    next_cycle();
    check_eq("w_idle_ready", 512'(in_ready), 512'(1));
    check_eq("w_idle_len", 512'(pkt_len), 512'(100));
    next_cycle();
    in_valid = 1'b0;
    #1;
    exp_hdr        = '0;
    exp_hdr[7:0]   = 8'hC1;
    check_eq("w_first_len", 512'(pkt_len), 512'(1));
    check_eq("w_first_hdr", hdr_bits(), exp_hdr);
    exp_hdr[15:8] = 8'hC2;
    send_byte(8'hC2, 1'b1);
    check_eq("p2_start", 512'(start), 512'(1));
    check_eq("p2_hdr", hdr_bits(), exp_hdr);
    check_eq("p2_len", 512'(pkt_len), 512'(2));
    next_cycle();
    finish_parser("p2", 3);

    // cfg_busy high for three cycles spanning start entry
    send_byte(8'h31, 1'b0);
    send_byte(8'h32, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_last  = 1'b1;
    cfg_busy = 1'b1;
    #1;
    check_eq("busy_c0_start", 512'(start), 512'(0));
    next_cycle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check_eq("busy_c1_start", 512'(start), 512'(0));
    check_eq("busy_c1_ready", 512'(in_ready), 512'(0));
    next_cycle();
    check_eq("busy_c2_start", 512'(start), 512'(0));
    check_eq("busy_c2_cnt", 512'(pkt_cnt), 512'(3));
    next_cycle();
    cfg_busy = 1'b0;
    #1;
    check_eq("busy_release_start", 512'(start), 512'(1));
    check_eq("busy_len", 512'(pkt_len), 512'(3));
    next_cycle();
    finish_parser("busy", 4);

    // Single-byte packet
    exp_hdr      = '0;
    exp_hdr[7:0] = 8'hAB;
    send_byte(8'hAB, 1'b1);
    check_eq("p1_start", 512'(start), 512'(1));
    check_eq("p1_hdr", hdr_bits(), exp_hdr);
    check_eq("p1_len", 512'(pkt_len), 512'(1));
    next_cycle();
    finish_parser("p1", 5);

    // Reset mid-packet, then a 4-byte packet
    for (int i = 0; i < 10; i++) send_byte(8'(8'h80 + i), 1'b0);
    check_eq("fill_len", 512'(pkt_len), 512'(10));
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_ready", 512'(in_ready), 512'(1));
    check_eq("mid_rst_start", 512'(start), 512'(0));
    check_eq("mid_rst_len", 512'(pkt_len), 512'(0));
    check_eq("mid_rst_cnt", 512'(pkt_cnt), 512'(0));
    check_eq("mid_rst_hdr", hdr_bits(), 512'(0));
    exp_hdr = '0;
    for (int i = 0; i < 4; i++) begin
      exp_hdr[i*8 +: 8] = 8'(8'h11 + i);
      send_byte(8'(8'h11 + i), i == 3);
    end
    check_eq("p4_start", 512'(start), 512'(1));
    check_eq("p4_hdr", hdr_bits(), exp_hdr);
    check_eq("p4_len", 512'(pkt_len), 512'(4));
    next_cycle();
    finish_parser("p4", 1);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/pkt_hdr_buffer.md
# pkt_hdr_buffer

Ingress stage directly upstream of the header parser. It accepts a byte-serial packet stream with a valid/ready/last handshake and captures the first `HDR_MAX_LEN` bytes into a parallel header array. It then pulses `start_o` to the parser and holds the array stable until the parser reports completion. Payload bytes beyond the header window are counted and discarded; they are not stored.

## Interface
Parameters:
- `HDR_MAX_LEN`, default `` `HDR_MAX_LEN ``: number of header bytes captured and presented to the parser.
- `LEN_W`, default 32 (`` `DATA_BUS `` width): width of the packet length output and the packet counter.

Ports:
- `clk`  in  1  the single clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  input byte valid.
- `in_data_i`  in  8 (`` `BYTE_BUS ``)  input byte.
- `in_last_i`  in  1  marks the final byte of a packet; qualified by `in_valid_i`.
- `in_ready_o`  out  1  the block can accept a byte this cycle.
- `start_o`  out  1  one-cycle start pulse to the parser's `start_i`.
- `pkt_hdr_o`  out  8 x `HDR_MAX_LEN`, indexed [0:HDR_MAX_LEN-1]  captured header bytes, driven to the parser's `pkt_hdr_i`.
- `pkt_len_o`  out  LEN_W  total byte count of the held packet.
- `parser_ready_i`  in  1  the parser's `ready_o`.
- `cfg_busy_i`  in  1  the parser's `mod_start_i`; while high the parser ignores `start_i`.
- `pkt_cnt_o`  out  LEN_W  number of packets handed to the parser; wraps at 2^LEN_W.

## Operation
- A byte is accepted in any cycle where `in_valid_i && in_ready_o`. `in_data_i` and `in_last_i` are ignored when `in_valid_i` is low. Valid gaps are allowed anywhere inside a packet.
- `in_ready_o` is decoded from the state: it is 1 in IDLE, FILL and DRAIN, and 0 in START and WAIT.
- States and transitions:
  - IDLE: on an accepted byte, write it to `pkt_hdr_o[0]`, clear indices 1..HDR_MAX_LEN-1 in the same cycle, and set the length counter to 1.
    - If `in_last_i` is high, go to START.
    - Otherwise go to FILL, or go to DRAIN if `HDR_MAX_LEN == 1`.
  - FILL: write each accepted byte to index `len`, then increment `len`.
    - If `in_last_i` is high, go to START.
    - Else, if the byte just written filled index HDR_MAX_LEN-1, go to DRAIN.
  - DRAIN: accepted bytes are discarded and only `len` increments. An accepted byte with `in_last_i` high moves the block to START.
  - START: while `cfg_busy_i` is 1, stay in START with `start_o` = 0. When `cfg_busy_i` is 0, assert `start_o` for exactly one cycle, increment `pkt_cnt_o`, clear `seen_low`, and go to WAIT.
  - WAIT: set `seen_low` whenever `parser_ready_i` is 0. When `seen_low` is set and `parser_ready_i` is 1, go to IDLE.
    - Rationale: `parser_ready_i` may still be high from the previous packet for one cycle after `start_o`.
- Packets shorter than `HDR_MAX_LEN` leave the remaining bytes at 0x00.
- `pkt_len_o` is updated in the same cycle as each accepted byte. It saturates at 2^LEN_W-1 and never wraps.
- `pkt_hdr_o` and `pkt_len_o` change only in IDLE, FILL and DRAIN. They are therefore stable from the `start_o` cycle until the return to IDLE.

## Timing
- Latency: last byte accepted on cycle N, then `start_o` high on cycle N+1 (when `cfg_busy_i` is 0).
- `pkt_hdr_o` is valid, with all bytes final, on the `start_o` cycle; the parser samples it then.
- The first byte of the next packet can be accepted on the first cycle in IDLE after WAIT exits.
- A simultaneous `cfg_busy_i` rise and START entry defers `start_o`. No start is ever lost or duplicated.
- Reset values: state IDLE, `start_o` 0, `pkt_hdr_o` all 0x00, `pkt_len_o` 0, `pkt_cnt_o` 0, `seen_low` 0. `in_ready_o` is 1 from the first cycle after reset.
- Reset mid-packet discards the partial packet. The next accepted byte is treated as index 0 of a new packet. Upstream is responsible for resynchronising to packet boundaries.

## Structure
- Shared package / `def.svh`:
  - state enum typedef `pkt_buf_state_t` {IDLE, FILL, DRAIN, START, WAIT};
  - reuse `` `HDR_MAX_LEN ``, `` `BYTE_BUS ``, `` `DATA_BUS ``, `` `TRUE ``/`` `FALSE ``.
- Single flat module; no sub-module is needed. The byte counter and the saturation logic are inline.

## Test plan
- 20-byte packet 0x01..0x14, no gaps, `HDR_MAX_LEN` = 64 -> `pkt_hdr_o[0..19]` = 0x01..0x14, [20..63] = 0x00, `pkt_len_o` = 20, `start_o` high exactly 1 cycle, on the cycle after the last byte, `pkt_cnt_o` = 1.
- 100-byte packet with random valid gaps -> `pkt_hdr_o` = first 64 bytes, `pkt_len_o` = 100, `in_ready_o` stays 1 throughout DRAIN.
- A second packet is offered during WAIT while `parser_ready_i` is held 1 for 1 cycle, 0 for 5 cycles, then 1:
  - `in_ready_o` = 0 until the rising `parser_ready_i`;
  - `pkt_hdr_o` is unchanged throughout;
  - the second packet's first byte is accepted the cycle after the return to IDLE.
- `cfg_busy_i` high for 3 cycles spanning START entry -> `start_o` stays low for 3 cycles, then pulses once on the first cycle `cfg_busy_i` is 0.
- Single-byte packet 0xAB (valid and last together) -> `pkt_hdr_o[0]` = 0xAB, rest 0x00, `pkt_len_o` = 1, `start_o` on the next cycle.
- `rst` asserted after 10 bytes in FILL -> all outputs return to reset values. A subsequent 4-byte packet 0x11..0x14 yields `pkt_hdr_o[0..3]` = 0x11..0x14 and `pkt_len_o` = 4.
